// File: rtl/stark_pkg.sv
// rtl/stark_pkg.sv - shared value/tag types and the reservation-station entry layout
package cpu_types_pkg;
  typedef logic [31:0] value_t;
  typedef logic [5:0]  pregno_t;
endpackage

package Stark_pkg;
  // arg[0] is argA ... arg[3] is argD
  typedef struct packed {
    logic [7:0]                  op;
    cpu_types_pkg::pregno_t      dst;
    cpu_types_pkg::value_t [3:0] arg;
  } reservation_station_entry_t;
endpackage

// File: rtl/stark_mul_rs_if.sv
// rtl/stark_mul_rs_if.sv - dispatch, wakeup and issue signals of the multiplier reservation station
interface stark_mul_rs_if #(
  parameter int WID = $bits(cpu_types_pkg::value_t)
);
  localparam int PW = $bits(cpu_types_pkg::pregno_t);

  logic                                   disp_v_i;
  logic                                   disp_rdy_o;
  Stark_pkg::reservation_station_entry_t  disp_rse_i;
  logic [3:0]                             disp_av_i;
  logic [4*PW-1:0]                        disp_tag_i;
  logic [1:0]                             wk_v_i;
  logic [2*PW-1:0]                        wk_tag_i;
  logic [2*WID-1:0]                       wk_val_i;
  logic                                   wb_stall_i;
  Stark_pkg::reservation_station_entry_t  rse_o;
  logic                                   iss_v_o;

  modport master (
    output disp_v_i, disp_rse_i, disp_av_i, disp_tag_i, wk_v_i, wk_tag_i, wk_val_i, wb_stall_i,
    input  disp_rdy_o, rse_o, iss_v_o
  );

  modport slave (
    input  disp_v_i, disp_rse_i, disp_av_i, disp_tag_i, wk_v_i, wk_tag_i, wk_val_i, wb_stall_i,
    output disp_rdy_o, rse_o, iss_v_o
  );
endinterface

// File: rtl/stark_mul_rs.sv
// rtl/stark_mul_rs.sv - multiplier reservation station with age-matrix oldest-ready issue
// Optional STARK_MULRS_BYPASS_EN: wakeup forwards straight into the select/issue path.
module stark_mul_rs #(
  parameter int NENT = 4,
  parameter int WID  = $bits(cpu_types_pkg::value_t)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  stark_mul_rs_if.slave         bus,
  output logic [$clog2(NENT):0] count_o,
  output logic [1:0]            inflight_o
);
  typedef Stark_pkg::reservation_station_entry_t rse_t;
  typedef cpu_types_pkg::value_t value_t;
  localparam int PW = $bits(cpu_types_pkg::pregno_t);
  localparam int IW = $clog2(NENT);
  localparam int CW = IW + 1;
  typedef logic [3:0][PW-1:0] tags_t;
  typedef struct packed {
    rse_t       e;
    logic [3:0] a;
  } woke_t;

  rse_t            ent_q [NENT];
  logic [3:0]      av_q  [NENT];
  tags_t           tag_q [NENT];
  logic [NENT-1:0] age_q [NENT];
  logic [NENT-1:0] vld_q;
  logic [CW-1:0]   count_q;
  logic [2:0]      sr_q;
  logic            iss_v_q;
  rse_t            rse_q;

  woke_t           woke [NENT];
  woke_t           disp_woke;
  rse_t            cand [NENT];
  logic [NENT-1:0] rdy;
  logic            sel_found;
  logic [IW-1:0]   sel_idx;
  logic [IW-1:0]   free_idx;
  logic            do_iss;
  logic            do_disp;

  // Bus 0 is checked first so it wins when both buses carry the operand's tag.
  function automatic woke_t wake(rse_t e, logic [3:0] a, tags_t t, logic [1:0] wv,
                                 logic [2*PW-1:0] wt, logic [2*WID-1:0] wval);
    woke_t r;
    r.e = e;
    r.a = a;
    for (int k = 0; k < 4; k++) begin
      if (!a[k]) begin
        if (wv[0] && (wt[PW-1:0] == t[k])) begin
          r.e.arg[k] = value_t'(wval[WID-1:0]);
          r.a[k]     = 1'b1;
        end else if (wv[1] && (wt[2*PW-1:PW] == t[k])) begin
          r.e.arg[k] = value_t'(wval[2*WID-1:WID]);
          r.a[k]     = 1'b1;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    rdy       = '0;
    disp_woke = wake(bus.disp_rse_i, bus.disp_av_i, tags_t'(bus.disp_tag_i),
                     bus.wk_v_i, bus.wk_tag_i, bus.wk_val_i);
    for (int i = 0; i < NENT; i++) begin
      woke[i] = wake(ent_q[i], av_q[i], tag_q[i], bus.wk_v_i, bus.wk_tag_i, bus.wk_val_i);
`ifdef STARK_MULRS_BYPASS_EN
      rdy[i]  = vld_q[i] & (&woke[i].a);
      cand[i] = woke[i].e;
`else
      rdy[i]  = vld_q[i] & (&av_q[i]);
      cand[i] = ent_q[i];
`endif
    end
  end

  // age_q[i][j] set means entry j is older than entry i.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    free_idx  = '0;
    for (int i = 0; i < NENT; i++) begin
      if (rdy[i] && !sel_found && ((rdy & age_q[i]) == '0)) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
    for (int i = NENT - 1; i >= 0; i--) begin
      if (!vld_q[i]) free_idx = IW'(i);
    end
  end

  assign bus.disp_rdy_o = (count_q < CW'(NENT));
  assign do_iss         = sel_found & ~bus.wb_stall_i & ~flush_i;
  assign do_disp        = bus.disp_v_i & bus.disp_rdy_o & ~flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      count_q <= '0;
      sr_q    <= '0;
      iss_v_q <= 1'b0;
      rse_q   <= '0;
      for (int i = 0; i < NENT; i++) age_q[i] <= '0;
    end else begin
      sr_q    <= {sr_q[1:0], iss_v_q};
      iss_v_q <= do_iss;
      if (do_iss) rse_q <= cand[sel_idx];
      for (int i = 0; i < NENT; i++) begin
        ent_q[i] <= woke[i].e;
        av_q[i]  <= woke[i].a;
      end
      if (flush_i) begin
        vld_q   <= '0;
        count_q <= '0;
        for (int i = 0; i < NENT; i++) age_q[i] <= '0;
      end else begin
        if (do_iss) vld_q[sel_idx] <= 1'b0;
        if (do_disp) begin
          vld_q[free_idx] <= 1'b1;
          ent_q[free_idx] <= disp_woke.e;
          av_q[free_idx]  <= disp_woke.a;
          tag_q[free_idx] <= tags_t'(bus.disp_tag_i);
          for (int j = 0; j < NENT; j++) age_q[j][free_idx] <= 1'b0;
          age_q[free_idx] <= vld_q;
        end
        count_q <= count_q + CW'(do_disp) - CW'(do_iss);
      end
    end
  end

  assign bus.rse_o   = rse_q;
  assign bus.iss_v_o = iss_v_q;
  assign count_o     = count_q;
  assign inflight_o  = 2'(sr_q[0]) + 2'(sr_q[1]) + 2'(sr_q[2]);
endmodule

// File: doc/stark_mul_rs.md
STARK_MUL_RS -- requirements
Module: stark_mul_rs

Interface
REQ-001 The block SHALL have parameter NENT, default 4, giving the number of reservation entries (power of two, 2..8).
REQ-002 The block SHALL have parameter WID, default $bits(cpu_types_pkg::value_t), giving the operand width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port flush_i  input  1  discard all held entries.
REQ-006 The block SHALL have port disp_v_i  input  1  dispatch request.
REQ-007 The block SHALL have port disp_rdy_o  output  1  at least one free entry.
REQ-008 The block SHALL have port disp_rse_i  input  Stark_pkg::reservation_station_entry_t  entry to hold.
REQ-009 The block SHALL have port disp_av_i  input  4  valid bits for argA, argB, argC, argD; bit 0 is argA.
REQ-010 The block SHALL have port disp_tag_i  input  4*$bits(pregno_t)  producer tags for argA..argD.
REQ-011 The block SHALL have port wk_v_i  input  2  wakeup bus valids.
REQ-012 The block SHALL have port wk_tag_i  input  2*$bits(pregno_t)  wakeup tags.
REQ-013 The block SHALL have port wk_val_i  input  2*WID  wakeup values.
REQ-014 The block SHALL have port wb_stall_i  input  1  writeback port busy; inhibits issue.
REQ-015 The block SHALL have port rse_o  output  Stark_pkg::reservation_station_entry_t  entry issued to the multiplier.
REQ-016 The block SHALL have port iss_v_o  output  1  rse_o valid this cycle.
REQ-017 The block SHALL have port count_o  output  $clog2(NENT)+1  number of occupied entries.
REQ-018 The block SHALL have port inflight_o  output  2  number of issued ops still in the 3-cycle multiplier pipeline (0..3).

Function
REQ-019 Dispatch SHALL occur when disp_v_i and disp_rdy_o are both high; the entry goes to the lowest-index free slot.
REQ-020 disp_rdy_o SHALL be registered-state based: high iff count_o < NENT, with no combinational path from disp_v_i.
REQ-021 A held entry SHALL be ready when all four operand valid bits are set.
REQ-022 When wk_v_i[k] is high and wk_tag_i[k] matches the tag of a pending operand, the block SHALL capture wk_val_i[k] into that operand and set its valid bit.
REQ-023 A wakeup in the same cycle as dispatch SHALL also be captured into the dispatching entry's matching operands.
REQ-024 If both wakeup buses match the same operand, bus 0 SHALL win.
REQ-025 Ordering SHALL be tracked by an NENT x NENT age matrix; each cycle the block SHALL select the oldest ready entry for issue.
REQ-026 Issue SHALL be registered: the selected entry appears on rse_o with iss_v_o high on the next cycle; iss_v_o is high for exactly one cycle per entry.
REQ-027 The issued slot SHALL be freed in the issue cycle and SHALL be reusable by a dispatch in the following cycle.
REQ-028 Dispatch into a slot freed in the same cycle SHALL NOT occur.
REQ-029 When wb_stall_i is high, no selection SHALL occur; held entries keep their state, and wakeup capture continues.
REQ-030 At most one entry SHALL be issued per cycle.
REQ-031 count_o SHALL change by +1 on dispatch and -1 on issue; simultaneous dispatch and issue SHALL leave it unchanged.
REQ-032 inflight_o SHALL equal the popcount of a 3-stage shift register fed by iss_v_o.
REQ-033 flush_i SHALL clear all entry valids and the age matrix next cycle, and SHALL suppress any issue and dispatch in that cycle.
REQ-034 flush_i SHALL NOT clear the in-flight shift register.
REQ-035 When no entry is selected, rse_o SHALL hold its previous value and iss_v_o SHALL be low.

Reset
REQ-036 On rst, all entries SHALL become invalid, the age matrix SHALL clear, the shift register SHALL clear, and rse_o SHALL be zero.
REQ-037 During and immediately after rst, iss_v_o = 0, count_o = 0, inflight_o = 0 and disp_rdy_o = 1.
REQ-038 rst SHALL take priority over flush_i, dispatch, wakeup and issue.

Configuration
REQ-039 With STARK_MULRS_BYPASS_EN defined, an entry whose last pending operand is woken in cycle N SHALL be selectable in cycle N, with the wakeup value forwarded into rse_o, so issue appears at cycle N+1.
REQ-040 Without STARK_MULRS_BYPASS_EN, that entry SHALL first be selectable in cycle N+1, so issue appears at cycle N+2, and there SHALL be no wakeup-to-select path.

Verification
REQ-041 Reset, then dispatch one entry with disp_av_i=4'hF -> iss_v_o high exactly 1 cycle after dispatch selection, count_o back to 0, inflight_o steps 1,1,1,0.
REQ-042 Fill all 4 slots with argB pending on tag 7, then pulse wk_v_i[0] with tag 7 and value 32'h1234 -> all four issue in dispatch order on consecutive cycles, each with argB=32'h1234, and disp_rdy_o low until the first issue.
REQ-043 Ready entry held while wb_stall_i is high for 3 cycles -> no iss_v_o during the stall, issue on the first cycle after stall release.
REQ-044 Both wake buses carry tag 5, bus0 value 1 and bus1 value 2 -> captured value 1.
REQ-045 Wakeup at cycle 10 completing an entry -> iss_v_o at cycle 11 with STARK_MULRS_BYPASS_EN, at cycle 12 without.
REQ-046 Assert flush_i with 3 entries held and 2 in flight -> count_o=0 next cycle, no issue, inflight_o still decays 2,…,0.
